// File: rtl/mandelbrot_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mandelbrot_pkg
// Purpose  : Shared types and constants for the Mandelbrot zoom sequencer.
// Revision : 1.0  initial release
// ============================================================================
package mandelbrot_pkg;

   localparam int FP_TOP  = 8;
   localparam int FP_BOT  = 24;
   localparam int FP_BITS = FP_TOP + FP_BOT;

   typedef logic signed [FP_BITS-1:0] fp_t;
   typedef logic [6:0]                zoom_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LAUNCH = 3'd1,
      CLEAR  = 3'd2,
      RENDER = 3'd3,
      DWELL  = 3'd4,
      STEP   = 3'd5,
      END    = 3'd6
   } seq_state_e;

   function automatic zoom_t zoom_step(input zoom_t z, input logic up);
      return up ? zoom_t'(z + 7'd1) : zoom_t'(z - 7'd1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mandelbrot_zoom_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : mandelbrot_zoom_sequencer_if
// Purpose  : Sequencer-to-renderer control bundle (reset, zoom, offsets, finished).
// Revision : 1.0  initial release
// ============================================================================
interface mandelbrot_zoom_sequencer_if #(
   parameter int FP_BITS = mandelbrot_pkg::FP_BITS
);
   logic                      rend_reset;
   logic [6:0]                rend_zoom;
   logic signed [FP_BITS-1:0] rend_x0;
   logic signed [FP_BITS-1:0] rend_y0;
   logic                      rend_finished;

   modport master (
      output rend_reset, rend_zoom, rend_x0, rend_y0,
      input  rend_finished
   );

   modport slave (
      input  rend_reset, rend_zoom, rend_x0, rend_y0,
      output rend_finished
   );
endinterface
`default_nettype wire

// File: rtl/mandelbrot_zoom_sequencer_cnt.sv
`default_nettype none
// ============================================================================
// Module   : seq_down_counter
// Purpose  : Loadable down counter that stops at zero; used for dwell and watchdog.
// Revision : 1.0  initial release
// ============================================================================
module seq_down_counter #(
   parameter int WIDTH = 32
) (
   input  wire logic             clk_calc,
   input  wire logic             reset,
   input  wire logic             load_i,
   input  wire logic [WIDTH-1:0] load_val_i,
   input  wire logic             en_i,
   output logic                  zero_o
);
   logic [WIDTH-1:0] cnt_q;

   always_ff @(posedge clk_calc) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign zero_o = (cnt_q == '0);
endmodule
`default_nettype wire

// File: rtl/mandelbrot_zoom_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mandelbrot_zoom_sequencer
// Purpose  : Frame-level zoom animation controller driving the Mandelbrot renderer.
//            Optional MANDEL_AUTOPAN_EN: offsets advance by pan_dx/pan_dy per zoom step.
// Revision : 1.0  initial release
// ============================================================================
module mandelbrot_zoom_sequencer #(
   parameter int FP_TOP       = 8,
   parameter int FP_BOT       = 24,
   parameter int RST_CYCLES   = 2,
   parameter int TIMEOUT_BITS = 32
) (
   input  wire logic                            clk_calc,
   input  wire logic                            reset,
   input  wire logic                            start,
   input  wire logic                            stop,
   input  wire logic [6:0]                      zoom_start,
   input  wire logic [6:0]                      zoom_end,
   input  wire logic                            loop_en,
   input  wire logic [31:0]                     dwell_cycles,
   input  wire logic [TIMEOUT_BITS-1:0]         timeout_cycles,
   input  wire logic signed [FP_TOP+FP_BOT-1:0] x0_init,
   input  wire logic signed [FP_TOP+FP_BOT-1:0] y0_init,
   input  wire logic signed [FP_TOP+FP_BOT-1:0] pan_dx,
   input  wire logic signed [FP_TOP+FP_BOT-1:0] pan_dy,
   mandelbrot_zoom_sequencer_if.master          rend,
   output logic                                 busy,
   output logic                                 frame_done,
   output logic [15:0]                          frame_count,
   output logic                                 done,
   output logic                                 timeout_err
);
   localparam int FP_BITS = FP_TOP + FP_BOT;
   localparam int RST_W   = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   import mandelbrot_pkg::*;

   seq_state_e                state_q, state_d;
   zoom_t                     zoom_q, zoom_d;
   logic signed [FP_BITS-1:0] x0_q, x0_d, y0_q, y0_d;
   logic                      rend_reset_q, rend_reset_d;
   logic                      busy_q, busy_d;
   logic                      frame_done_q, frame_done_d;
   logic [15:0]               frame_count_q, frame_count_d;
   logic                      done_q, done_d;
   logic                      timeout_err_q, timeout_err_d;
   logic                      stop_pending_q, stop_pending_d;
   logic [RST_W-1:0]          rst_cnt_q, rst_cnt_d;

   zoom_t                     cfg_zs_q, cfg_zs_d, cfg_ze_q, cfg_ze_d;
   logic                      cfg_loop_q, cfg_loop_d, cfg_up_q, cfg_up_d;
   logic [31:0]               cfg_dwell_q, cfg_dwell_d;
   logic [TIMEOUT_BITS-1:0]   cfg_timeout_q, cfg_timeout_d;
   logic signed [FP_BITS-1:0] cfg_x0_q, cfg_x0_d, cfg_y0_q, cfg_y0_d;
`ifdef MANDEL_AUTOPAN_EN
   logic signed [FP_BITS-1:0] cfg_dx_q, cfg_dx_d, cfg_dy_q, cfg_dy_d;
`else
   logic                      unused_pan;
   assign unused_pan = ^{pan_dx, pan_dy};
`endif

   logic dwell_load, dwell_en, dwell_zero;
   logic wd_load, wd_en, wd_zero, wd_expired;
   logic at_end;

   seq_down_counter #(.WIDTH(32)) u_dwell_cnt (
      .clk_calc   (clk_calc),
      .reset      (reset),
      .load_i     (dwell_load),
      .load_val_i (cfg_dwell_q - 32'd1),
      .en_i       (dwell_en),
      .zero_o     (dwell_zero)
   );

   seq_down_counter #(.WIDTH(TIMEOUT_BITS)) u_wd_cnt (
      .clk_calc   (clk_calc),
      .reset      (reset),
      .load_i     (wd_load),
      .load_val_i (cfg_timeout_q - 1'b1),
      .en_i       (wd_en),
      .zero_o     (wd_zero)
   );

   // Watchdog is loaded with timeout-1, so zero marks the timeout-th CLEAR/RENDER cycle.
   assign wd_expired = (cfg_timeout_q != '0) && wd_zero;
   assign at_end     = (zoom_q == cfg_ze_q);

   always_comb begin
      state_d        = state_q;
      zoom_d         = zoom_q;
      x0_d           = x0_q;
      y0_d           = y0_q;
      rend_reset_d   = rend_reset_q;
      busy_d         = busy_q;
      frame_done_d   = 1'b0;
      frame_count_d  = frame_count_q;
      done_d         = done_q;
      timeout_err_d  = timeout_err_q;
      stop_pending_d = stop_pending_q;
      rst_cnt_d      = rst_cnt_q;
      cfg_zs_d       = cfg_zs_q;
      cfg_ze_d       = cfg_ze_q;
      cfg_loop_d     = cfg_loop_q;
      cfg_up_d       = cfg_up_q;
      cfg_dwell_d    = cfg_dwell_q;
      cfg_timeout_d  = cfg_timeout_q;
      cfg_x0_d       = cfg_x0_q;
      cfg_y0_d       = cfg_y0_q;
`ifdef MANDEL_AUTOPAN_EN
      cfg_dx_d       = cfg_dx_q;
      cfg_dy_d       = cfg_dy_q;
`endif
      dwell_load     = 1'b0;
      dwell_en       = 1'b0;
      wd_load        = 1'b0;
      wd_en          = 1'b0;

      if ((state_q != IDLE) && stop) stop_pending_d = 1'b1;

      case (state_q)
         IDLE: begin
            if (start) begin
               cfg_zs_d       = zoom_start;
               cfg_ze_d       = zoom_end;
               cfg_loop_d     = loop_en;
               cfg_up_d       = (zoom_end >= zoom_start);
               cfg_dwell_d    = dwell_cycles;
               cfg_timeout_d  = timeout_cycles;
               cfg_x0_d       = x0_init;
               cfg_y0_d       = y0_init;
`ifdef MANDEL_AUTOPAN_EN
               cfg_dx_d       = pan_dx;
               cfg_dy_d       = pan_dy;
`endif
               zoom_d         = zoom_start;
               x0_d           = x0_init;
               y0_d           = y0_init;
               rend_reset_d   = 1'b1;
               busy_d         = 1'b1;
               frame_count_d  = 16'd0;
               done_d         = 1'b0;
               timeout_err_d  = 1'b0;
               stop_pending_d = 1'b0;
               rst_cnt_d      = RST_W'(RST_CYCLES - 1);
               state_d        = LAUNCH;
            end
         end
         LAUNCH: begin
            if (rst_cnt_q == '0) begin
               rend_reset_d = 1'b0;
               wd_load      = 1'b1;
               state_d      = CLEAR;
            end else begin
               rst_cnt_d = rst_cnt_q - 1'b1;
            end
         end
         CLEAR: begin
            wd_en = 1'b1;
            if (wd_expired) begin
               timeout_err_d = 1'b1;
               state_d       = END;
            end else if (!rend.rend_finished) begin
               state_d = RENDER;
            end
         end
         RENDER: begin
            wd_en = 1'b1;
            if (rend.rend_finished) begin
               frame_done_d  = 1'b1;
               frame_count_d = frame_count_q + 16'd1;
               if (cfg_dwell_q == 32'd0) begin
                  state_d = STEP;
               end else begin
                  dwell_load = 1'b1;
                  state_d    = DWELL;
               end
            end else if (wd_expired) begin
               timeout_err_d = 1'b1;
               state_d       = END;
            end
         end
         DWELL: begin
            dwell_en = 1'b1;
            if (dwell_zero) state_d = STEP;
         end
         STEP: begin
            if (stop_pending_q || stop || (at_end && !cfg_loop_q)) begin
               state_d = END;
            end else begin
               if (at_end) begin
                  zoom_d = cfg_zs_q;
                  x0_d   = cfg_x0_q;
                  y0_d   = cfg_y0_q;
               end else begin
                  zoom_d = zoom_step(zoom_q, cfg_up_q);
`ifdef MANDEL_AUTOPAN_EN
                  x0_d   = x0_q + cfg_dx_q;
                  y0_d   = y0_q + cfg_dy_q;
`endif
               end
               rend_reset_d = 1'b1;
               rst_cnt_d    = RST_W'(RST_CYCLES - 1);
               state_d      = LAUNCH;
            end
         end
         END: begin
            busy_d         = 1'b0;
            done_d         = 1'b1;
            stop_pending_d = 1'b0;
            state_d        = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_calc) begin
      if (reset) begin
         state_q        <= IDLE;
         zoom_q         <= '0;
         x0_q           <= '0;
         y0_q           <= '0;
         rend_reset_q   <= 1'b1;
         busy_q         <= 1'b0;
         frame_done_q   <= 1'b0;
         frame_count_q  <= 16'd0;
         done_q         <= 1'b0;
         timeout_err_q  <= 1'b0;
         stop_pending_q <= 1'b0;
         rst_cnt_q      <= '0;
         cfg_zs_q       <= '0;
         cfg_ze_q       <= '0;
         cfg_loop_q     <= 1'b0;
         cfg_up_q       <= 1'b0;
         cfg_dwell_q    <= '0;
         cfg_timeout_q  <= '0;
         cfg_x0_q       <= '0;
         cfg_y0_q       <= '0;
`ifdef MANDEL_AUTOPAN_EN
         cfg_dx_q       <= '0;
         cfg_dy_q       <= '0;
`endif
      end else begin
         state_q        <= state_d;
         zoom_q         <= zoom_d;
         x0_q           <= x0_d;
         y0_q           <= y0_d;
         rend_reset_q   <= rend_reset_d;
         busy_q         <= busy_d;
         frame_done_q   <= frame_done_d;
         frame_count_q  <= frame_count_d;
         done_q         <= done_d;
         timeout_err_q  <= timeout_err_d;
         stop_pending_q <= stop_pending_d;
         rst_cnt_q      <= rst_cnt_d;
         cfg_zs_q       <= cfg_zs_d;
         cfg_ze_q       <= cfg_ze_d;
         cfg_loop_q     <= cfg_loop_d;
         cfg_up_q       <= cfg_up_d;
         cfg_dwell_q    <= cfg_dwell_d;
         cfg_timeout_q  <= cfg_timeout_d;
         cfg_x0_q       <= cfg_x0_d;
         cfg_y0_q       <= cfg_y0_d;
`ifdef MANDEL_AUTOPAN_EN
         cfg_dx_q       <= cfg_dx_d;
         cfg_dy_q       <= cfg_dy_d;
`endif
      end
   end

   assign rend.rend_reset = rend_reset_q;
   assign rend.rend_zoom  = zoom_q;
   assign rend.rend_x0    = x0_q;
   assign rend.rend_y0    = y0_q;
   assign busy            = busy_q;
   assign frame_done      = frame_done_q;
   assign frame_count     = frame_count_q;
   assign done            = done_q;
   assign timeout_err     = timeout_err_q;
endmodule
`default_nettype wire
